// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide unit for a single-cycle core.
//
// State table:
//   IDLE | waiting for an M-extension instruction; operands are latched on accept
//   CALC | one shift-add (multiply) or restoring-divide step per cycle, 32 cycles
//   DONE | result on wb_data_o/wb_rd_o, wb_en_o strobes for this single cycle
//
// Ports:
//   clk_i, rst_i         clock (rising edge), synchronous active-high reset
//   start_i, flush_i     instruction present / abort current operation
//   funct3_i             MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   rs1_data_i           operand A / dividend
//   rs2_data_i           operand B / divisor
//   rd_i                 destination register index
//   stall_o              combinational hold request for PC/fetch
//   busy_o               registered, high whenever state is not IDLE
//   wb_data_o, wb_rd_o   result word and destination, held outside DONE
//   wb_en_o              one-cycle write-back strobe
module mul_div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic [4:0]      wb_rd_o,
  output logic            wb_en_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        funct3_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   b_q;
  // Multiply: {high partial product, multiplier shifting out}.
  // Divide: low half holds dividend bits shifting out / quotient bits shifting in.
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   rem_q;
  logic              neg_q;
  logic              rem_neg_q;
  logic              busy_q;
  logic              wb_en_q;
  logic [XLEN-1:0]   wb_data_q;
  logic [4:0]        wb_rd_q;

  // Operand decode for the accept cycle
  logic            a_signed, b_signed;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;

  always_comb begin
    a_signed = (funct3_i == F_MULH) || (funct3_i == F_MULHSU) ||
               (funct3_i == F_DIV)  || (funct3_i == F_REM);
    b_signed = (funct3_i == F_MULH) || (funct3_i == F_DIV) || (funct3_i == F_REM);
    a_neg    = a_signed & rs1_data_i[XLEN-1];
    b_neg    = b_signed & rs2_data_i[XLEN-1];
    a_mag    = a_neg ? -rs1_data_i : rs1_data_i;
    b_mag    = b_neg ? -rs2_data_i : rs2_data_i;

    div_zero = funct3_i[2] && (rs2_data_i == '0);
    div_ovf  = ((funct3_i == F_DIV) || (funct3_i == F_REM)) &&
               (rs1_data_i == MIN_NEG) && (rs2_data_i == ALL_ONES);
    special  = div_zero || div_ovf;

    // funct3[1] selects remainder among the divide ops
    if (div_zero) begin
      special_res = funct3_i[1] ? rs1_data_i : ALL_ONES;
    end else begin
      special_res = funct3_i[1] ? '0 : MIN_NEG;
    end
  end

  // One iteration step for both algorithms, plus the final result formed from
  // the step outputs so the last CALC cycle can load wb_data directly.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] acc_mul_d;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic              q_bit;
  logic [XLEN-1:0]   rem_d;
  logic [2*XLEN-1:0] acc_div_d;
  logic [2*XLEN-1:0] acc_d;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem_fin;
  logic [XLEN-1:0]   result_d;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? b_q : '0)};
    acc_mul_d = {mul_sum, acc_q[XLEN-1:1]};

    // 33-bit trial subtraction; borrow in the top bit means "restore"
    div_shift = {rem_q, acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_q};
    q_bit     = ~div_diff[XLEN];
    rem_d     = q_bit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
    acc_div_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], q_bit};

    acc_d   = funct3_q[2] ? acc_div_d : acc_mul_d;
    prod    = neg_q ? -acc_mul_d : acc_mul_d;
    quo     = neg_q ? -acc_div_d[XLEN-1:0] : acc_div_d[XLEN-1:0];
    rem_fin = rem_neg_q ? -rem_d : rem_d;

    case (funct3_q)
      F_MUL:                     result_d = prod[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU: result_d = prod[2*XLEN-1:XLEN];
      F_DIV, F_DIVU:             result_d = quo;
      default:                   result_d = rem_fin;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      funct3_q  <= '0;
      rd_q      <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      busy_q    <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_data_q <= '0;
      wb_rd_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          wb_en_q <= 1'b0;
          if (start_i && !flush_i) begin
            funct3_q  <= funct3_i;
            rd_q      <= rd_i;
            b_q       <= b_mag;
            acc_q     <= {{XLEN{1'b0}}, a_mag};
            rem_q     <= '0;
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            if (special) begin
              state_q   <= DONE;
              wb_data_q <= special_res;
              wb_rd_q   <= rd_i;
              wb_en_q   <= (rd_i != 5'd0);
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          if (flush_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            wb_en_q <= 1'b0;
          end else begin
            acc_q <= acc_d;
            rem_q <= rem_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
              state_q   <= DONE;
              wb_data_q <= result_d;
              wb_rd_q   <= rd_q;
              wb_en_q   <= (rd_q != 5'd0);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          wb_en_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          wb_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign stall_o   = ((state_q == IDLE) && start_i && !flush_i) || (state_q == CALC);
  assign busy_o    = busy_q;
  // A flush landing on the DONE cycle must still kill the write-back
  assign wb_en_o   = wb_en_q & ~flush_i;
  assign wb_data_o = wb_data_q;
  assign wb_rd_o   = wb_rd_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed-vector bench for mul_div_unit.
module tb_mul_div_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        flush_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [4:0]  rd_i;
  logic        stall_o;
  logic        busy_o;
  logic [31:0] wb_data_o;
  logic [4:0]  wb_rd_o;
  logic        wb_en_o;

  int checks = 0;
  int errors = 0;

  mul_div_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .flush_i    (flush_i),
    .funct3_i   (funct3_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .rd_i       (rd_i),
    .stall_o    (stall_o),
    .busy_o     (busy_o),
    .wb_data_o  (wb_data_o),
    .wb_rd_o    (wb_rd_o),
    .wb_en_o    (wb_en_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  // Start an op in the current cycle T, wait for DONE and check latency,
  // stall span, result, and the return to IDLE. pulse_at > 0 re-asserts
  // start_i with different inputs at T+pulse_at, which must be ignored.
  task automatic run_op(input string tag, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int exp_lat,
                        input logic [31:0] exp, input int pulse_at);
    int n;
    int stalls;
    funct3_i = f; rs1_data_i = a; rs2_data_i = b; rd_i = rd; start_i = 1'b1;
    #1;
    chk({tag, "_stall_T"}, {31'b0, stall_o}, 32'd1);
    tick();
    start_i = 1'b0;
    n = 1;
    stalls = 0;
    while (!wb_en_o && n < 40) begin
      if (n == pulse_at) begin
        start_i = 1'b1; funct3_i = 3'b000;
        rs1_data_i = 32'd9; rs2_data_i = 32'd9; rd_i = 5'd9;
        #1;
      end
      stalls += int'(stall_o);
      tick();
      start_i = 1'b0;
      n++;
    end
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_stall_cycles"}, stalls, exp_lat - 1);
    chk({tag, "_data"}, wb_data_o, exp);
    chk({tag, "_rd"}, {27'b0, wb_rd_o}, {27'b0, rd});
    chk({tag, "_stall_done"}, {31'b0, stall_o}, 32'd0);
    tick();
    chk({tag, "_busy_after"}, {31'b0, busy_o}, 32'd0);
    chk({tag, "_wben_after"}, {31'b0, wb_en_o}, 32'd0);
    chk({tag, "_hold"}, wb_data_o, exp);
  endtask

  initial begin
    int wb_seen;
    rst_i = 1'b1; start_i = 1'b0; flush_i = 1'b0; funct3_i = 3'b000;
    rs1_data_i = '0; rs2_data_i = '0; rd_i = '0;
    tick();
    tick();
    chk("rst_busy",  {31'b0, busy_o},  32'd0);
    chk("rst_wben",  {31'b0, wb_en_o}, 32'd0);
    chk("rst_data",  wb_data_o,        32'd0);
    chk("rst_rd",    {27'b0, wb_rd_o}, 32'd0);
    chk("rst_stall", {31'b0, stall_o}, 32'd0);
    rst_i = 1'b0;
    tick();

    // Multiply
    run_op("mul",    3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  33, 32'hFFFF_FFEB, 0);
    run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  33, 32'h4000_0000, 0);
    run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  33, 32'hFFFF_FFFE, 0);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 5'd8,  33, 32'hFFFF_FFFF, 0);
    run_op("mulhsu2",3'b010, 32'h0000_0002, 32'hFFFF_FFFF, 5'd8,  33, 32'h0000_0001, 0);

    // Divide
    run_op("div",    3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd10, 33, 32'hFFFF_FFFD, 0);
    run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd11, 33, 32'hFFFF_FFFF, 0);
    run_op("divu",   3'b101, 32'd100,       32'd7,         5'd12, 33, 32'd14,        0);
    run_op("remu",   3'b111, 32'd100,       32'd7,         5'd13, 33, 32'd2,         0);
    run_op("div_n2", 3'b100, 32'd100,       32'hFFFF_FFF9, 5'd14, 33, 32'hFFFF_FFF2, 0);

    // Special cases
    run_op("divu_z", 3'b101, 32'd5,         32'd0,         5'd15, 1, 32'hFFFF_FFFF, 0);
    run_op("rem_z",  3'b110, 32'd5,         32'd0,         5'd16, 1, 32'd5,         0);
    run_op("div_ov", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 1, 32'h8000_0000, 0);
    run_op("rem_ov", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 1, 32'd0,         0);

    // start_i pulsed mid-CALC is ignored
    run_op("ign_start", 3'b101, 32'd100, 32'd7, 5'd3, 33, 32'd14, 12);

    // Flush mid-CALC, then a fresh MUL
    funct3_i = 3'b100; rs1_data_i = 32'd1000; rs2_data_i = 32'd3; rd_i = 5'd20;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wb_seen = 0;
    for (int i = 1; i < 10; i++) begin
      wb_seen += int'(wb_en_o);
      tick();
    end
    flush_i = 1'b1;
    #1;
    wb_seen += int'(wb_en_o);
    tick();
    flush_i = 1'b0;
    chk("flush_busy", {31'b0, busy_o},  32'd0);
    chk("flush_wben", {31'b0, wb_en_o}, 32'd0);
    wb_seen += int'(wb_en_o);
    tick();
    chk("flush_no_wb", wb_seen, 32'd0);
    run_op("mul_after_flush", 3'b000, 32'd3, 32'd4, 5'd7, 33, 32'd12, 0);

    // Flush on the DONE cycle suppresses the strobe
    funct3_i = 3'b101; rs1_data_i = 32'd5; rs2_data_i = 32'd0; rd_i = 5'd4;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    flush_i = 1'b1;
    #1;
    chk("flush_done_wben", {31'b0, wb_en_o}, 32'd0);
    chk("flush_done_data", wb_data_o, 32'hFFFF_FFFF);
    tick();
    flush_i = 1'b0;
    chk("flush_done_busy", {31'b0, busy_o}, 32'd0);

    // Flush in IDLE blocks acceptance
    funct3_i = 3'b000; rs1_data_i = 32'd2; rs2_data_i = 32'd2; rd_i = 5'd2;
    start_i = 1'b1; flush_i = 1'b1;
    #1;
    chk("idle_flush_stall", {31'b0, stall_o}, 32'd0);
    tick();
    start_i = 1'b0; flush_i = 1'b0;
    chk("idle_flush_busy", {31'b0, busy_o}, 32'd0);

    // rd = 0: result computed but never written back
    funct3_i = 3'b000; rs1_data_i = 32'd2; rs2_data_i = 32'd3; rd_i = 5'd0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wb_seen = 0;
    for (int i = 1; i < 33; i++) begin
      wb_seen += int'(wb_en_o);
      tick();
    end
    chk("rd0_busy_done", {31'b0, busy_o},  32'd1);
    chk("rd0_stall_done", {31'b0, stall_o}, 32'd0);
    chk("rd0_wben", {31'b0, wb_en_o}, 32'd0);
    chk("rd0_data", wb_data_o, 32'd6);
    chk("rd0_no_wb", wb_seen, 32'd0);
    tick();
    chk("rd0_busy_after", {31'b0, busy_o}, 32'd0);

    // Reset mid-CALC
    funct3_i = 3'b000; rs1_data_i = 32'd5; rs2_data_i = 32'd5; rd_i = 5'd9;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 1; i < 20; i++) tick();
    chk("pre_rst_busy", {31'b0, busy_o}, 32'd1);
    rst_i = 1'b1;
    tick();
    chk("mid_rst_busy",  {31'b0, busy_o},  32'd0);
    chk("mid_rst_wben",  {31'b0, wb_en_o}, 32'd0);
    chk("mid_rst_data",  wb_data_o,        32'd0);
    chk("mid_rst_rd",    {27'b0, wb_rd_o}, 32'd0);
    chk("mid_rst_stall", {31'b0, stall_o}, 32'd0);
    rst_i = 1'b0;
    tick();

    run_op("remu_after_rst", 3'b111, 32'd50, 32'd8, 5'd1, 33, 32'd2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
